// File: rtl/snn_pkg.sv
// Shared SNN definitions: accumulator FSM states, default array geometry and
// the accumulator width derivation used by the weight store and its consumers.
package snn_pkg;

  localparam int NUM_SYNAPSES_DEF = 100;
  localparam int WIDTH_DEF        = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } acc_state_e;

  // Wide enough for NUM_SYNAPSES maximum-valued weights, so the sum never wraps.
  function automatic int acc_width(input int num_synapses, input int width);
    return width + $clog2(num_synapses);
  endfunction

endpackage

// File: rtl/synapse_accumulator_if.sv
// Request/result bundle between a pass requester (master) and the synapse
// accumulator (slave).
interface synapse_accumulator_if
  import snn_pkg::*;
#(
  parameter int NUM_SYNAPSES = NUM_SYNAPSES_DEF,
  parameter int WIDTH_P      = WIDTH_DEF
);

  localparam int ACC_W = acc_width(NUM_SYNAPSES, WIDTH_P);

  logic [NUM_SYNAPSES*WIDTH_P-1:0] weights_i;
  logic [NUM_SYNAPSES-1:0]         spikes_i;
  logic                            start_i;
  logic                            busy_o;
  logic                            done_o;
  logic [ACC_W-1:0]                sum_o;
  logic                            spike_o;

  modport master (
    output weights_i, spikes_i, start_i,
    input  busy_o, done_o, sum_o, spike_o
  );

  modport slave (
    input  weights_i, spikes_i, start_i,
    output busy_o, done_o, sum_o, spike_o
  );

endinterface

// File: rtl/synapse_accumulator_weight_mux.sv
// Combinational selection of one weight from the flat weight bus. Indices past
// the last synapse yield zero rather than reading outside the bus.
module synapse_accumulator_weight_mux #(
  parameter int NUM_SYNAPSES = 100,
  parameter int WIDTH_P      = 8,
  parameter int IDX_W        = 7
) (
  input  logic [NUM_SYNAPSES*WIDTH_P-1:0] weights_i,
  input  logic [IDX_W-1:0]                idx_i,
  output logic [WIDTH_P-1:0]              weight_o
);

  always_comb begin
    weight_o = '0;
    for (int k = 0; k < NUM_SYNAPSES; k++) begin
      if (idx_i == IDX_W'(k)) weight_o = weights_i[k*WIDTH_P +: WIDTH_P];
    end
  end

endmodule

// File: rtl/synapse_accumulator.sv
// Scans the weight array one synapse per cycle, summing weights of spiking
// inputs, and reports the sum plus a threshold comparison with fixed latency.
module synapse_accumulator
  import snn_pkg::*;
#(
  parameter int NUM_SYNAPSES = NUM_SYNAPSES_DEF,
  parameter int WIDTH_P      = WIDTH_DEF,
  parameter int THRESHOLD    = 256
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  synapse_accumulator_if.slave bus
);

  localparam int ACC_W = acc_width(NUM_SYNAPSES, WIDTH_P);
  localparam int IDX_W = $clog2(NUM_SYNAPSES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYNAPSES - 1);

  acc_state_e              state;
  logic [IDX_W-1:0]        idx;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        acc_nxt;
  logic [NUM_SYNAPSES-1:0] snap;
  logic [WIDTH_P-1:0]      weight;

  synapse_accumulator_weight_mux #(
    .NUM_SYNAPSES (NUM_SYNAPSES),
    .WIDTH_P      (WIDTH_P),
    .IDX_W        (IDX_W)
  ) u_weight_mux (
    .weights_i (bus.weights_i),
    .idx_i     (idx),
    .weight_o  (weight)
  );

  // Spikes come from the snapshot so the caller may move on after start.
  always_comb begin
    acc_nxt = acc;
    if (snap[idx]) acc_nxt = acc + ACC_W'(weight);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      snap        <= '0;
      bus.busy_o  <= 1'b0;
      bus.done_o  <= 1'b0;
      bus.sum_o   <= '0;
      bus.spike_o <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            snap       <= bus.spikes_i;
            acc        <= '0;
            idx        <= '0;
            bus.busy_o <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          acc <= acc_nxt;
          if (idx == LAST_IDX) begin
            bus.sum_o   <= acc_nxt;
            bus.spike_o <= (32'(acc_nxt) >= 32'(THRESHOLD));
            bus.busy_o  <= 1'b0;
            bus.done_o  <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
